// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and range clamp for the servo slew stage.
package servo_pkg;

    localparam int unsigned DC_W           = 21;
    localparam int unsigned MIN_DC         = 100000;
    localparam int unsigned MAX_DC         = 200000;
    localparam int unsigned CENTER_DC      = 150000;
    localparam int unsigned STEP_DC        = 2000;
    localparam int unsigned SETTLE_PERIODS = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLAMP,
        S_MOVE,
        S_SETTLE
    } servo_state_t;

    function automatic int unsigned clamp_dc(input int unsigned raw,
                                             input int unsigned lo,
                                             input int unsigned hi);
        if (raw < lo) return lo;
        if (raw > hi) return hi;
        return raw;
    endfunction

endpackage

// File: rtl/servo_slew.sv
// Clamps accepted duty-cycle targets and slews the PWM duty cycle toward them,
// one bounded step per PWM period tick.
module servo_slew #(
    parameter int unsigned DC_W           = servo_pkg::DC_W,
    parameter int unsigned MIN_DC         = servo_pkg::MIN_DC,
    parameter int unsigned MAX_DC         = servo_pkg::MAX_DC,
    parameter int unsigned CENTER_DC      = servo_pkg::CENTER_DC,
    parameter int unsigned STEP_DC        = servo_pkg::STEP_DC,
    parameter int unsigned SETTLE_PERIODS = servo_pkg::SETTLE_PERIODS
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [DC_W-1:0] target_in,
    input  logic            target_valid_in,
    output logic            target_ready_out,
    input  logic            period_tick_in,
    output logic [DC_W-1:0] dc_out,
    output logic            clamped_out,
    output logic            settled_out
);
    import servo_pkg::*;

    localparam int unsigned        CNT_W    = $clog2(SETTLE_PERIODS + 2);
    localparam logic [DC_W-1:0]    MIN_V    = DC_W'(MIN_DC);
    localparam logic [DC_W-1:0]    MAX_V    = DC_W'(MAX_DC);
    localparam logic [DC_W-1:0]    CENTER_V = DC_W'(CENTER_DC);
    localparam logic [DC_W-1:0]    STEP_V   = DC_W'(STEP_DC);
    localparam logic [DC_W:0]      STEP_W   = (DC_W + 1)'(STEP_DC);
    localparam logic [CNT_W-1:0]   SETTLE_V = CNT_W'(SETTLE_PERIODS);

    servo_state_t state_q, state_d;

    logic [DC_W-1:0]  dc_q, dc_d;
    logic [DC_W-1:0]  target_q, target_d;
    logic [DC_W-1:0]  raw_q, raw_d;
    logic             tick_pend_q, tick_pend_d;
    logic             settled_q, settled_d;
    logic             clamped_q, clamped_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

    logic             accept;
    logic             tick;
    logic [DC_W-1:0]  clamped_val;
    logic             raw_out_of_range;
    logic signed [DC_W:0] diff;
    logic [DC_W:0]    diff_mag;
    logic             within_step;
    logic [DC_W-1:0]  stepped_dc;
    logic [CNT_W-1:0] settle_first;
    logic [CNT_W-1:0] settle_inc;

    assign target_ready_out = (state_q != S_CLAMP);
    assign accept           = target_valid_in && target_ready_out;
    assign tick             = period_tick_in || tick_pend_q;

    assign clamped_val      = DC_W'(clamp_dc(32'(raw_q), MIN_DC, MAX_DC));
    assign raw_out_of_range = (raw_q < MIN_V) || (raw_q > MAX_V);

    // One extra bit keeps the sign of target-minus-output exact over the full range.
    assign diff        = $signed({1'b0, target_q}) - $signed({1'b0, dc_q});
    assign diff_mag    = diff[DC_W] ? $unsigned(-diff) : $unsigned(diff);
    assign within_step = (diff_mag <= STEP_W);
    assign stepped_dc  = diff[DC_W] ? (dc_q - STEP_V) : (dc_q + STEP_V);

    assign settle_first = period_tick_in ? CNT_W'(1) : '0;
    assign settle_inc   = settle_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        dc_d         = dc_q;
        target_d     = target_q;
        raw_d        = raw_q;
        tick_pend_d  = 1'b0;
        settled_d    = settled_q;
        clamped_d    = 1'b0;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    raw_d     = target_in;
                    settled_d = 1'b0;
                    state_d   = S_CLAMP;
                end
            end

            S_CLAMP: begin
                target_d  = clamped_val;
                clamped_d = raw_out_of_range;
                if (clamped_val != dc_q) begin
                    tick_pend_d = period_tick_in;
                    state_d     = S_MOVE;
                end else begin
                    // A tick arriving here is the first settle period.
                    settle_cnt_d = settle_first;
                    state_d      = S_SETTLE;
                    if (settle_first >= SETTLE_V) begin
                        settled_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_MOVE: begin
                if (tick) begin
                    if (within_step) begin
                        dc_d         = target_q;
                        settle_cnt_d = '0;
                        state_d      = S_SETTLE;
                    end else begin
                        dc_d = stepped_dc;
                    end
                end
                // The step above uses the old target; the new one is clamped next.
                if (accept) begin
                    raw_d     = target_in;
                    settled_d = 1'b0;
                    state_d   = S_CLAMP;
                end
            end

            S_SETTLE: begin
                if (accept) begin
                    raw_d     = target_in;
                    settled_d = 1'b0;
                    state_d   = S_CLAMP;
                end else if (tick) begin
                    settle_cnt_d = settle_inc;
                    if (settle_inc >= SETTLE_V) begin
                        settled_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            dc_q         <= CENTER_V;
            target_q     <= CENTER_V;
            raw_q        <= CENTER_V;
            tick_pend_q  <= 1'b0;
            settled_q    <= 1'b1;
            clamped_q    <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            dc_q         <= dc_d;
            target_q     <= target_d;
            raw_q        <= raw_d;
            tick_pend_q  <= tick_pend_d;
            settled_q    <= settled_d;
            clamped_q    <= clamped_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign dc_out      = dc_q;
    assign clamped_out = clamped_q;
    assign settled_out = settled_q;

endmodule

// File: tb/tb_servo_slew.sv
// Scoreboard bench for servo_slew: directed and random targets/ticks against a
// per-period slew model; a monitor matches every output change to a queued expectation.
`timescale 1ns/1ps
module tb_servo_slew;

    localparam int unsigned DC_W      = 21;
    localparam int          MIN_DC    = 100000;
    localparam int          MAX_DC    = 200000;
    localparam int          CENTER_DC = 150000;
    localparam int          STEP_DC   = 2000;
    localparam int          SETTLE_P  = 3;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [DC_W-1:0] target_in;
    logic            target_valid_in;
    logic            target_ready_out;
    logic            period_tick_in;
    logic [DC_W-1:0] dc_out;
    logic            clamped_out;
    logic            settled_out;

    always #5 clk_in = ~clk_in;

    servo_slew #(
        .DC_W(DC_W), .MIN_DC(MIN_DC), .MAX_DC(MAX_DC), .CENTER_DC(CENTER_DC),
        .STEP_DC(STEP_DC), .SETTLE_PERIODS(SETTLE_P)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .target_in(target_in), .target_valid_in(target_valid_in),
        .target_ready_out(target_ready_out), .period_tick_in(period_tick_in),
        .dc_out(dc_out), .clamped_out(clamped_out), .settled_out(settled_out)
    );

    typedef struct { int cyc; int val; } ev_t;
    ev_t dc_ev[$];
    ev_t cl_ev[$];
    ev_t st_ev[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    int last_dc;
    int last_st;

    // Reference model: output slews toward the current clamped target on each period.
    int m_dc, m_tgt, m_raw, m_cnt;
    bit m_clamp_next, m_pend, m_settling, m_settled;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int clampf(input int r);
        if (r < MIN_DC) return MIN_DC;
        if (r > MAX_DC) return MAX_DC;
        return r;
    endfunction

    task automatic model_reset();
        m_dc = CENTER_DC; m_tgt = CENTER_DC; m_raw = CENTER_DC; m_cnt = 0;
        m_clamp_next = 0; m_pend = 0; m_settling = 0; m_settled = 1;
    endtask

    task automatic settle_tick(input int n);
        m_cnt++;
        if (m_cnt >= SETTLE_P) begin
            m_settling = 0;
            m_settled  = 1;
            st_ev.push_back('{n, 1});
        end
    endtask

    task automatic model_edge(input int n, input bit v, input int t, input bit tk);
        bit acc;
        bit te;
        int nt;
        int gap;
        acc = v && !m_clamp_next;
        if (m_clamp_next) begin
            nt = clampf(m_raw);
            if (nt != m_raw) cl_ev.push_back('{n, 1});
            m_tgt = nt;
            m_clamp_next = 0;
            if (nt != m_dc) m_pend = tk;
            else begin
                m_settling = 1;
                m_cnt = 0;
                if (tk) settle_tick(n);
            end
        end else begin
            te = tk || m_pend;
            m_pend = 0;
            if (te && m_dc != m_tgt) begin
                gap = (m_tgt > m_dc) ? m_tgt - m_dc : m_dc - m_tgt;
                if (gap > STEP_DC) gap = STEP_DC;
                m_dc = (m_tgt > m_dc) ? m_dc + gap : m_dc - gap;
                dc_ev.push_back('{n, m_dc});
                if (m_dc == m_tgt) begin m_settling = 1; m_cnt = 0; end
            end else if (te && m_settling && !acc) begin
                settle_tick(n);
            end
            if (acc) begin
                m_raw = t;
                m_clamp_next = 1;
                m_settling = 0;
                if (m_settled) st_ev.push_back('{n, 0});
                m_settled = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input int t, input bit tk);
        @(negedge clk_in);
        chk("ready", int'(target_ready_out), m_clamp_next ? 0 : 1);
        // The source holds target_in stable while a valid offer is not ready.
        if (!(m_clamp_next && target_valid_in)) target_in = DC_W'(t);
        target_valid_in = v;
        period_tick_in  = tk;
        model_edge(cyc + 1, v, int'(target_in), tk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, int'(target_in), 1'b0);
    endtask

    task automatic tick_once();
        drive(1'b0, int'(target_in), 1'b1);
        idle(2);
    endtask

    task automatic accept(input int t);
        drive(1'b1, t, 1'b0);
        idle(2);
    endtask

    task automatic run_to_settle(input string name);
        int k;
        k = 0;
        while (!m_settled && k < 300) begin
            tick_once();
            k++;
        end
        if (!m_settled) begin
            checks++;
            errors++;
            $display("FAIL %s: model did not settle within 300 ticks", name);
        end
    endtask

    always @(negedge clk_in) begin
        ev_t e;
        if (mon_en) begin
            if (int'(dc_out) != last_dc) begin
                last_dc = int'(dc_out);
                checks++;
                if (dc_ev.size() == 0) begin
                    errors++;
                    $display("FAIL dc_change: got %0d at cycle %0d, expected no change", last_dc, cyc);
                end else begin
                    e = dc_ev.pop_front();
                    if (e.val != last_dc || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL dc_change: got %0d at cycle %0d, expected %0d at cycle %0d",
                                 last_dc, cyc, e.val, e.cyc);
                    end
                end
            end
            if (clamped_out !== 1'b0) begin
                checks++;
                if (cl_ev.size() == 0) begin
                    errors++;
                    $display("FAIL clamped_pulse: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = cl_ev.pop_front();
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL clamped_pulse: got pulse at cycle %0d, expected at cycle %0d", cyc, e.cyc);
                    end
                end
            end
            if (int'(settled_out) != last_st) begin
                last_st = int'(settled_out);
                checks++;
                if (st_ev.size() == 0) begin
                    errors++;
                    $display("FAIL settled_change: got %0d at cycle %0d, expected no change", last_st, cyc);
                end else begin
                    e = st_ev.pop_front();
                    if (e.val != last_st || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL settled_change: got %0d at cycle %0d, expected %0d at cycle %0d",
                                 last_st, cyc, e.val, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int sel;
        bit v;
        bit tk;

        rst_in = 1'b0; target_in = '0; target_valid_in = 1'b0; period_tick_in = 1'b0;
        model_reset();
        last_dc = CENTER_DC;
        last_st = 1;
        repeat (3) @(negedge clk_in);
        chk("reset_dc", int'(dc_out), CENTER_DC);
        chk("reset_settled", int'(settled_out), 1);
        chk("reset_ready", int'(target_ready_out), 1);
        chk("reset_clamped", int'(clamped_out), 0);
        rst_in = 1'b1;
        mon_en = 1'b1;

        // Ticks with no target leave the output home and settled.
        for (int i = 0; i < 5; i++) begin
            tick_once();
            chk("idle_settled", int'(settled_out), 1);
        end
        chk("idle_dc", int'(dc_out), CENTER_DC);

        accept(160000);
        for (int i = 0; i < 5; i++) tick_once();
        chk("ramp_160000", int'(dc_out), 160000);
        for (int i = 0; i < 3; i++) tick_once();
        chk("ramp_settled", int'(settled_out), 1);

        accept(250000);
        run_to_settle("high_clamp");
        chk("clamp_high_dc", int'(dc_out), MAX_DC);
        accept(50000);
        run_to_settle("low_clamp");
        chk("clamp_low_dc", int'(dc_out), MIN_DC);

        accept(150000);
        run_to_settle("home");
        accept(160000);
        for (int i = 0; i < 3; i++) tick_once();
        chk("retarget_start", int'(dc_out), 156000);
        accept(151000);
        run_to_settle("retarget");
        chk("retarget_end", int'(dc_out), 151000);

        // Tick with an accept in MOVE, then a tick during CLAMP.
        accept(170000);
        tick_once();
        drive(1'b1, 165000, 1'b1);
        drive(1'b0, 165000, 1'b1);
        idle(2);
        chk("pending_tick_dc", int'(dc_out), 157000);
        run_to_settle("pending_tick");
        chk("pending_tick_end", int'(dc_out), 165000);

        // Target equal to the output: a tick in CLAMP is the first settle period.
        drive(1'b1, 165000, 1'b0);
        drive(1'b0, 165000, 1'b1);
        idle(2);
        tick_once();
        chk("same_target_not_yet", int'(settled_out), 0);
        tick_once();
        chk("same_target_settled", int'(settled_out), 1);

        // Valid held through the unready CLAMP cycle is not a second accept.
        drive(1'b1, 180000, 1'b0);
        drive(1'b1, 180000, 1'b0);
        idle(2);
        run_to_settle("held_valid");
        chk("held_valid_dc", int'(dc_out), 180000);

        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 9) == 0);
            tk  = ($urandom_range(0, 4) == 0);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       t = int'($urandom_range(0, MIN_DC - 1));
                1:       t = int'($urandom_range(MAX_DC + 1, (1 << DC_W) - 1));
                2:       t = m_dc;
                default: t = int'($urandom_range(MIN_DC, MAX_DC));
            endcase
            drive(v, t, tk);
        end
        idle(2);
        run_to_settle("random_drain");
        idle(3);
        chk("dc_queue_empty", dc_ev.size(), 0);
        chk("clamp_queue_empty", cl_ev.size(), 0);
        chk("settled_queue_empty", st_ev.size(), 0);

        // Asynchronous reset in the middle of a ramp, with a tick in the same cycle.
        accept(170000);
        run_to_settle("pre_reset");
        accept(200000);
        for (int i = 0; i < 5; i++) tick_once();
        chk("pre_reset_dc", int'(dc_out), 180000);
        @(negedge clk_in);
        mon_en = 1'b0;
        period_tick_in = 1'b1;
        rst_in = 1'b0;
        #1;
        chk("async_reset_dc", int'(dc_out), CENTER_DC);
        chk("async_reset_settled", int'(settled_out), 1);
        chk("async_reset_ready", int'(target_ready_out), 1);
        chk("async_reset_clamped", int'(clamped_out), 0);
        @(negedge clk_in);
        period_tick_in = 1'b0;
        chk("reset_hold_dc", int'(dc_out), CENTER_DC);
        chk("reset_hold_clamped", int'(clamped_out), 0);
        rst_in = 1'b1;
        model_reset();
        dc_ev.delete();
        cl_ev.delete();
        st_ev.delete();
        last_dc = CENTER_DC;
        last_st = 1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) tick_once();
        chk("post_reset_dc", int'(dc_out), CENTER_DC);
        chk("post_reset_settled", int'(settled_out), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
